rx_cmd_parser: RTL and testbench

RX_CMD_PARSER -- requirements
Module: rx_cmd_parser

---
 rtl/rx_cmd_parser_pkg.sv | 65 ++++++
 rtl/rx_cmd_timer.sv | 38 +++
 rtl/rx_cmd_parser.sv | 217 +++++++++++++++++++++
 tb/tb_rx_cmd_parser.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: opcode bytes, command-type
// encodings, parser state encodings and the opcode decode helper.
package rx_cmd_parser_pkg;

   // Opcode bytes as they arrive from the UART receiver
   localparam logic [7:0] OP_WR      = 8'hAA;
   localparam logic [7:0] OP_RD      = 8'hBB;
   localparam logic [7:0] OP_ALU     = 8'hCC;
   localparam logic [7:0] OP_ALU_NOP = 8'hDD;

   // Command type presented on o_cmd_type
   typedef enum logic [1:0] {
      CMD_WR      = 2'd0,
      CMD_RD      = 2'd1,
      CMD_ALU     = 2'd2,
      CMD_ALU_NOP = 2'd3
   } cmd_type_e;

   // Parser states (plain constants so older code can share the encoding)
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_GET_ADDR = 3'd1;
   localparam logic [2:0] ST_GET_D0   = 3'd2;
   localparam logic [2:0] ST_GET_D1   = 3'd3;
   localparam logic [2:0] ST_GET_FUN  = 3'd4;
   localparam logic [2:0] ST_HOLD     = 3'd5;

   // Result of looking at an opcode byte: is it known, which command does it
   // start, and which field is collected first.
   typedef struct packed {
      logic       known;
      cmd_type_e  ctype;
      logic [2:0] first;
   } op_decode_t;

   function automatic op_decode_t decode_opcode(input logic [7:0] op);
      op_decode_t d;
      d.known = 1'b1;
      d.ctype = CMD_WR;
      d.first = ST_GET_ADDR;
      case (op)
         OP_WR: d.ctype = CMD_WR;
         OP_RD: d.ctype = CMD_RD;
         OP_ALU: begin
            d.ctype = CMD_ALU;
            d.first = ST_GET_D0;
         end
         OP_ALU_NOP: begin
            d.ctype = CMD_ALU_NOP;
            d.first = ST_GET_FUN;
         end
         default: begin
            d.known = 1'b0;
            d.first = ST_IDLE;
         end
      endcase
      return d;
   endfunction

   // True while a frame is being collected (the inter-byte timeout applies)
   function automatic logic is_get_state(input logic [2:0] st);
      return (st == ST_GET_ADDR) || (st == ST_GET_D0) ||
             (st == ST_GET_D1)   || (st == ST_GET_FUN);
   endfunction

endpackage

// File: rtl/rx_cmd_timer.sv
// Inter-byte timeout timer for the command parser.
// Down-counter loaded with TIMEOUT_CYC-1; each enabled cycle counts one idle
// cycle, and expired is the terminal-count (zero) compare.
// Ports:
//   clk     - clock
//   rst     - asynchronous active-high reset (counter reloads)
//   clear   - reload the counter (byte accepted or not inside a frame)
//   enable  - count one idle cycle
//   expired - TIMEOUT_CYC-1 idle cycles have been counted
module rx_cmd_timer #(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= LOAD;
      end else if (clear) begin
         cnt <= LOAD;
      end else if (enable && (cnt != '0)) begin
         // holds at zero; the parser leaves the frame on the same edge
         cnt <= cnt - CW'(1);
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/rx_cmd_parser.sv
// UART command frame parser.
// Assembles opcode + operand bytes from the UART receiver into one command
// and holds it until the downstream block accepts it.
//   0xAA WR      : addr, data
//   0xBB RD      : addr
//   0xCC ALU     : A, B, fun
//   0xDD ALU_NOP : fun
// Ports:
//   i_clk, i_rst   - clock, asynchronous active-high reset
//   i_data         - received byte, qualified by the i_data_valid strobe
//   i_cmd_ready    - downstream accepts the pending command
//   o_cmd_valid    - complete command presented (held until accepted)
//   o_cmd_type     - WR=0, RD=1, ALU=2, ALU_NOP=3
//   o_addr         - register address (WR, RD)
//   o_data_a       - write data (WR) or operand A (ALU)
//   o_data_b       - operand B (ALU)
//   o_fun          - ALU function (ALU, ALU_NOP)
//   o_cmd_err      - one-cycle pulse: unknown opcode or inter-byte timeout
//   o_ovf_err      - one-cycle pulse: byte dropped while a command is held
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for an opcode byte
// GET_ADDR | next byte is the register address (WR, RD)
// GET_D0   | next byte is write data (WR) or operand A (ALU)
// GET_D1   | next byte is operand B (ALU)
// GET_FUN  | next byte carries the ALU function (ALU, ALU_NOP)
// HOLD     | command presented, waiting for i_cmd_ready
module rx_cmd_parser
   import rx_cmd_parser_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int ADDR_WIDTH  = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [WIDTH-1:0]      i_data,
   input  logic                  i_data_valid,
   input  logic                  i_cmd_ready,
   output logic                  o_cmd_valid,
   output logic [1:0]            o_cmd_type,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [WIDTH-1:0]      o_data_a,
   output logic [WIDTH-1:0]      o_data_b,
   output logic [3:0]            o_fun,
   output logic                  o_cmd_err,
   output logic                  o_ovf_err
);

   logic [2:0]            state, state_nxt;
   cmd_type_e             cmd_type, type_nxt;
   logic [ADDR_WIDTH-1:0] addr, addr_nxt;
   logic [WIDTH-1:0]      data_a, a_nxt;
   logic [WIDTH-1:0]      data_b, b_nxt;
   logic [3:0]            fun, fun_nxt;
   logic                  cmd_err, err_nxt;
   logic                  ovf_err, ovf_nxt;

   logic                  start;
   logic                  abort;
   logic                  clear_fields;
   logic                  upper_zero;
   logic                  opcode_ok;
   op_decode_t            dec;

   logic                  in_get;
   logic                  timer_clear;
   logic                  timer_enable;
   logic                  timer_expired;

   // Opcodes are 8-bit values; on a wider bus the extra bits must be zero
   if (WIDTH > 8) begin : g_wide
      assign upper_zero = (i_data[WIDTH-1:8] == '0);
   end else begin : g_narrow
      assign upper_zero = 1'b1;
   end

   assign dec       = decode_opcode(i_data[7:0]);
   assign opcode_ok = dec.known && upper_zero;

   assign in_get       = is_get_state(state);
   assign timer_clear  = !in_get || i_data_valid;
   assign timer_enable = in_get && !i_data_valid;

   rx_cmd_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk     (i_clk),
      .rst     (i_rst),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   always_comb begin
      state_nxt    = state;
      type_nxt     = cmd_type;
      addr_nxt     = addr;
      a_nxt        = data_a;
      b_nxt        = data_b;
      fun_nxt      = fun;
      err_nxt      = 1'b0;
      ovf_nxt      = 1'b0;
      start        = 1'b0;
      abort        = 1'b0;
      clear_fields = 1'b0;

      case (state)
         ST_IDLE: begin
            start = i_data_valid;
         end
         ST_GET_ADDR: begin
            if (i_data_valid) begin
               addr_nxt  = i_data[ADDR_WIDTH-1:0];
               state_nxt = (cmd_type == CMD_WR) ? ST_GET_D0 : ST_HOLD;
            end else if (timer_expired) begin
               abort = 1'b1;
            end
         end
         ST_GET_D0: begin
            if (i_data_valid) begin
               a_nxt     = i_data;
               state_nxt = (cmd_type == CMD_ALU) ? ST_GET_D1 : ST_HOLD;
            end else if (timer_expired) begin
               abort = 1'b1;
            end
         end
         ST_GET_D1: begin
            if (i_data_valid) begin
               b_nxt     = i_data;
               state_nxt = ST_GET_FUN;
            end else if (timer_expired) begin
               abort = 1'b1;
            end
         end
         ST_GET_FUN: begin
            if (i_data_valid) begin
               fun_nxt   = i_data[3:0];
               state_nxt = ST_HOLD;
            end else if (timer_expired) begin
               abort = 1'b1;
            end
         end
         ST_HOLD: begin
            if (i_cmd_ready) begin
               // a byte arriving with the handshake opens the next frame
               state_nxt    = ST_IDLE;
               clear_fields = 1'b1;
               start        = i_data_valid;
            end else if (i_data_valid) begin
               ovf_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (abort) begin
         state_nxt    = ST_IDLE;
         clear_fields = 1'b1;
         err_nxt      = 1'b1;
      end

      // fields a command does not use must read as zero when presented
      if (clear_fields || start) begin
         type_nxt = CMD_WR;
         addr_nxt = '0;
         a_nxt    = '0;
         b_nxt    = '0;
         fun_nxt  = '0;
      end

      if (start) begin
         if (opcode_ok) begin
            type_nxt  = dec.ctype;
            state_nxt = dec.first;
         end else begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         cmd_type <= CMD_WR;
         addr     <= '0;
         data_a   <= '0;
         data_b   <= '0;
         fun      <= '0;
         cmd_err  <= 1'b0;
         ovf_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cmd_type <= type_nxt;
         addr     <= addr_nxt;
         data_a   <= a_nxt;
         data_b   <= b_nxt;
         fun      <= fun_nxt;
         cmd_err  <= err_nxt;
         ovf_err  <= ovf_nxt;
      end
   end

   assign o_cmd_valid = (state == ST_HOLD);
   assign o_cmd_type  = cmd_type;
   assign o_addr      = addr;
   assign o_data_a    = data_a;
   assign o_data_b    = data_b;
   assign o_fun       = fun;
   assign o_cmd_err   = cmd_err;
   assign o_ovf_err   = ovf_err;

endmodule

// File: tb/tb_rx_cmd_parser.sv
module tb_rx_cmd_parser;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data = 8'h00;
   logic       data_valid = 1'b0;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic [1:0] cmd_type;
   logic [3:0] addr;
   logic [7:0] data_a;
   logic [7:0] data_b;
   logic [3:0] fun;
   logic       cmd_err;
   logic       ovf_err;

   int checks = 0;
   int errors = 0;

   logic [28:0] obs;
   logic [2:0]  ctrl;
   assign obs  = {cmd_valid, cmd_type, addr, data_a, data_b, fun, cmd_err, ovf_err};
   assign ctrl = {cmd_valid, cmd_err, ovf_err};

   rx_cmd_parser #(
      .WIDTH       (8),
      .ADDR_WIDTH  (4),
      .TIMEOUT_CYC (TO)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_data       (data),
      .i_data_valid (data_valid),
      .i_cmd_ready  (cmd_ready),
      .o_cmd_valid  (cmd_valid),
      .o_cmd_type   (cmd_type),
      .o_addr       (addr),
      .o_data_a     (data_a),
      .o_data_b     (data_b),
      .o_fun        (fun),
      .o_cmd_err    (cmd_err),
      .o_ovf_err    (ovf_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model (frame level) ----------------
   logic [7:0] m_frame[$];
   int         m_idle;
   logic       m_valid, m_err, m_ovf;
   logic [1:0] m_type;
   logic [3:0] m_addr;
   logic [7:0] m_a, m_b;
   logic [3:0] m_fun;

   function automatic int frame_len(input logic [7:0] op);
      case (op)
         8'hAA:   return 3;
         8'hBB:   return 2;
         8'hCC:   return 4;
         8'hDD:   return 2;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_frame.delete();
      m_idle = 0;
      m_valid = 0; m_err = 0; m_ovf = 0;
      m_type = 0; m_addr = 0; m_a = 0; m_b = 0; m_fun = 0;
   endtask

   task automatic build_cmd();
      m_type = 0; m_addr = 0; m_a = 0; m_b = 0; m_fun = 0;
      case (m_frame[0])
         8'hAA: begin m_type = 2'd0; m_addr = m_frame[1][3:0]; m_a = m_frame[2]; end
         8'hBB: begin m_type = 2'd1; m_addr = m_frame[1][3:0]; end
         8'hCC: begin m_type = 2'd2; m_a = m_frame[1]; m_b = m_frame[2]; m_fun = m_frame[3][3:0]; end
         default: begin m_type = 2'd3; m_fun = m_frame[1][3:0]; end
      endcase
      m_valid = 1;
      m_frame.delete();
   endtask

   task automatic model_step(input logic v, input logic [7:0] d, input logic r);
      logic start;
      start = 0;
      m_err = 0;
      m_ovf = 0;
      if (m_valid) begin
         if (r) begin
            m_valid = 0;
            start = v;
         end else if (v) begin
            m_ovf = 1;
         end
      end else if (m_frame.size() == 0) begin
         start = v;
      end else if (v) begin
         m_frame.push_back(d);
         m_idle = 0;
         if (m_frame.size() == frame_len(m_frame[0])) build_cmd();
      end else if (m_idle == TO - 1) begin
         m_frame.delete();
         m_err = 1;
      end else begin
         m_idle++;
      end
      if (start) begin
         if (frame_len(d) == 0) begin
            m_err = 1;
         end else begin
            m_frame.delete();
            m_frame.push_back(d);
            m_idle = 0;
         end
      end
   endtask

   // one clock: drive at negedge, advance model at posedge, settle #1
   task automatic tick(input logic v, input logic [7:0] d, input logic r);
      @(negedge clk);
      data_valid = v;
      data = d;
      cmd_ready = r;
      @(posedge clk);
      if (rst) model_reset();
      else model_step(v, d, r);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (obs !== 29'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0", obs);
      end
      rst = 1'b0;
   endtask

   task automatic test_write();
      tick(1, 8'hAA, 1);
      tick(1, 8'h05, 1);
      checks++;
      if (ctrl !== 3'b000) begin errors++; $display("FAIL wr_early_valid got %b want 000", ctrl); end
      tick(1, 8'h3C, 1);
      checks++;
      if (obs !== {1'b1, 2'd0, 4'd5, 8'h3C, 8'h00, 4'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL wr_cmd got %h", obs);
      end
      tick(0, 8'h00, 1);
      checks++;
      if (ctrl !== 3'b000) begin errors++; $display("FAIL wr_release got %b want 000", ctrl); end
   endtask

   task automatic test_alu_hold();
      logic [28:0] exp;
      exp = {1'b1, 2'd2, 4'd0, 8'h07, 8'h03, 4'd2, 1'b0, 1'b0};
      tick(1, 8'hCC, 0);
      tick(1, 8'h07, 0);
      tick(1, 8'h03, 0);
      tick(1, 8'h02, 0);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL alu_cmd got %h want %h", obs, exp); end
      for (int i = 0; i < 10; i++) begin
         tick(0, 8'h00, 0);
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL alu_stable cyc %0d got %h want %h", i, obs, exp); end
      end
      tick(0, 8'h00, 1);
      checks++;
      if (ctrl !== 3'b000) begin errors++; $display("FAIL alu_release got %b want 000", ctrl); end
   endtask

   task automatic test_bad_opcode();
      tick(1, 8'h11, 0);
      checks++;
      if (ctrl !== 3'b010) begin errors++; $display("FAIL badop_err got %b want 010", ctrl); end
      tick(0, 8'h00, 0);
      checks++;
      if (ctrl !== 3'b000) begin errors++; $display("FAIL badop_pulse got %b want 000", ctrl); end
      tick(1, 8'hBB, 0);
      tick(1, 8'h09, 0);
      checks++;
      if (obs !== {1'b1, 2'd1, 4'd9, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL badop_rd got %h", obs);
      end
      tick(0, 8'h00, 1);
   endtask

   task automatic test_timeout();
      tick(1, 8'hAA, 0);
      tick(1, 8'h05, 0);
      for (int i = 1; i <= TO; i++) begin
         tick(0, 8'h00, 0);
         checks++;
         if (i < TO) begin
            if (ctrl !== 3'b000) begin errors++; $display("FAIL to_early cyc %0d got %b want 000", i, ctrl); end
         end else begin
            if (ctrl !== 3'b010) begin errors++; $display("FAIL to_err got %b want 010", ctrl); end
         end
      end
      tick(0, 8'h00, 0);
      checks++;
      if (ctrl !== 3'b000) begin errors++; $display("FAIL to_pulse got %b want 000", ctrl); end
      tick(1, 8'hDD, 0);
      tick(1, 8'h04, 0);
      checks++;
      if (obs !== {1'b1, 2'd3, 4'd0, 8'h00, 8'h00, 4'd4, 1'b0, 1'b0}) begin
         errors++; $display("FAIL to_nop got %h", obs);
      end
      tick(0, 8'h00, 1);
   endtask

   task automatic test_timeout_priority();
      tick(1, 8'hAA, 0);
      tick(1, 8'h05, 0);
      for (int i = 0; i < TO - 1; i++) tick(0, 8'h00, 0);
      checks++;
      if (ctrl !== 3'b000) begin errors++; $display("FAIL prio_early got %b want 000", ctrl); end
      tick(1, 8'h3C, 0);
      checks++;
      if (obs !== {1'b1, 2'd0, 4'd5, 8'h3C, 8'h00, 4'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL prio_cmd got %h", obs);
      end
      tick(0, 8'h00, 1);
   endtask

   task automatic test_overflow();
      logic [28:0] exp;
      exp = {1'b1, 2'd0, 4'd2, 8'h77, 8'h00, 4'd0, 1'b0, 1'b0};
      tick(1, 8'hAA, 0);
      tick(1, 8'h02, 0);
      tick(1, 8'h77, 0);
      tick(1, 8'h55, 0);
      checks++;
      if (obs !== (exp | 29'd1)) begin errors++; $display("FAIL ovf_pulse got %h want %h", obs, exp | 29'd1); end
      tick(0, 8'h00, 0);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL ovf_held got %h want %h", obs, exp); end
      tick(1, 8'hDD, 1);
      checks++;
      if (ctrl !== 3'b000) begin errors++; $display("FAIL ovf_handoff got %b want 000", ctrl); end
      tick(1, 8'h09, 0);
      checks++;
      if (obs !== {1'b1, 2'd3, 4'd0, 8'h00, 8'h00, 4'd9, 1'b0, 1'b0}) begin
         errors++; $display("FAIL ovf_next got %h", obs);
      end
      tick(0, 8'h00, 1);
   endtask

   task automatic test_back_to_back();
      tick(1, 8'hBB, 0);
      tick(1, 8'h03, 0);
      tick(1, 8'h42, 1);
      checks++;
      if (ctrl !== 3'b010) begin errors++; $display("FAIL b2b_badop got %b want 010", ctrl); end
      tick(1, 8'hBB, 0);
      tick(1, 8'h0E, 0);
      tick(1, 8'hBB, 1);
      checks++;
      if (ctrl !== 3'b000) begin errors++; $display("FAIL b2b_handoff got %b want 000", ctrl); end
      tick(1, 8'h0A, 1);
      checks++;
      if (obs !== {1'b1, 2'd1, 4'd10, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL b2b_rd got %h", obs);
      end
      tick(0, 8'h00, 1);
   endtask

   task automatic test_reset_midframe();
      tick(1, 8'hCC, 0);
      tick(1, 8'h07, 0);
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== 29'd0) begin errors++; $display("FAIL rst_mid_async got %h want 0", obs); end
      tick(0, 8'h00, 0);
      rst = 1'b0;
      tick(1, 8'hBB, 0);
      tick(1, 8'h01, 0);
      checks++;
      if (obs !== {1'b1, 2'd1, 4'd1, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0}) begin
         errors++; $display("FAIL rst_mid_rd got %h", obs);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== 29'd0) begin errors++; $display("FAIL rst_hold_async got %h want 0", obs); end
      tick(0, 8'h00, 0);
      rst = 1'b0;
      tick(0, 8'h00, 0);
      checks++;
      if (ctrl !== 3'b000) begin errors++; $display("FAIL rst_no_err got %b want 000", ctrl); end
   endtask

   task automatic test_random();
      logic [7:0] ops [4];
      int p_valid [4];
      int p_ready [4];
      logic v, r;
      logic [7:0] d;
      ops = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      p_valid = '{80, 40, 10, 3};
      p_ready = '{70, 30, 90, 50};
      for (int ph = 0; ph < 4; ph++) begin
         for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 99) < p_valid[ph]);
            r = ($urandom_range(0, 99) < p_ready[ph]);
            if ($urandom_range(0, 9) < 6) d = ops[$urandom_range(0, 3)];
            else d = 8'($urandom_range(0, 255));
            tick(v, d, r);
            checks++;
            if (ctrl !== {m_valid, m_err, m_ovf}) begin
               errors++;
               $display("FAIL rand_ctrl ph %0d cyc %0d got %b want %b", ph, i, ctrl, {m_valid, m_err, m_ovf});
            end
            if (m_valid) begin
               checks++;
               if (obs[27:2] !== {m_type, m_addr, m_a, m_b, m_fun}) begin
                  errors++;
                  $display("FAIL rand_fields ph %0d cyc %0d got %h want %h", ph, i, obs[27:2],
                           {m_type, m_addr, m_a, m_b, m_fun});
               end
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_write();
      test_alu_hold();
      test_bad_opcode();
      test_timeout();
      test_timeout_priority();
      test_overflow();
      test_back_to_back();
      test_reset_midframe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
